dmem_ctrl: RTL and testbench

Data-memory access controller between the single-cycle datapath's memory stage and a synchronous data RAM with a fixed multi-cycle read latency. It turns the datapath's MemRead/MemWrite, address (ALUResult) and store data (ReadData2) into RAM strobes. It freezes the datapath with `stall` until load data is available, then returns the data on `rdata`, which feeds the datapath's ReadData input.

---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_ctrl.sv | 96 +++++++++
 tb/tb_dmem_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and constants for the data-memory access controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_DONE    = 2'd2
    } state_e;

    localparam logic [3:0] WE_WORD = 4'hF;
    localparam int         CNT_W   = 4;

endpackage

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: posts word stores, stalls the datapath across
// the fixed RAM read latency and returns captured load data on rdata.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [29:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q;
    logic             capture;
    logic             aligned;

    assign aligned   = (addr[1:0] == 2'b00);
    assign ram_addr  = addr[31:2];
    assign ram_wdata = wdata;
    assign rdata     = rdata_q;

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        capture  = 1'b0;
        stall    = 1'b0;
        misalign = 1'b0;
        ram_en   = 1'b0;
        ram_we   = '0;

        case (state_q)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    if (!aligned) begin
                        misalign = 1'b1;
                    end else if (mem_read) begin
                        // A read wins over a simultaneous write; the write is dropped.
                        stall   = 1'b1;
                        ram_en  = 1'b1;
                        cnt_d   = CNT_W'(LAT - 1);
                        state_d = S_RD_WAIT;
                    end else begin
                        ram_en = 1'b1;
                        ram_we = WE_WORD;
                    end
                end
            end
            S_RD_WAIT: begin
                stall = 1'b1;
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (!rst) begin
            stall    = 1'b0;
            misalign = 1'b0;
            ram_en   = 1'b0;
            ram_we   = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) rdata_q <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: LAT=2 and LAT=1 instances share one stimulus stream, each
// with its own latency-accurate RAM and a cycle-age reference model.
module tb_dmem_ctrl;

    localparam int N = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] addr, wdata;

    logic [31:0]  rdata     [N];
    logic [N-1:0] stall, misalign, ram_en;
    logic [3:0]   ram_we    [N];
    logic [29:0]  ram_addr  [N];
    logic [31:0]  ram_wdata [N];
    logic [31:0]  ram_rdata [N];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0001_0001;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_lane
        localparam int L = (g == 0) ? 2 : 1;

        logic [31:0] mem     [256];
        logic [31:0] pipe    [L];
        logic [31:0] ref_mem [256];
        int          age;
        logic [31:0] exp_rdata, pending;
        logic        e_stall, e_en, e_mis;
        logic [3:0]  e_we;

        dmem_ctrl #(.LAT(L)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .mem_read  (mem_read),
            .mem_write (mem_write),
            .addr      (addr),
            .wdata     (wdata),
            .rdata     (rdata[g]),
            .stall     (stall[g]),
            .misalign  (misalign[g]),
            .ram_en    (ram_en[g]),
            .ram_we    (ram_we[g]),
            .ram_addr  (ram_addr[g]),
            .ram_wdata (ram_wdata[g]),
            .ram_rdata (ram_rdata[g])
        );

        assign ram_rdata[g] = pipe[L-1];

        // RAM: read data appears L cycles after the strobe cycle; garbage otherwise.
        initial begin
            for (int i = 0; i < 256; i++) mem[i] = init_word(i);
            mem[8'h40] = 32'hDEAD_BEEF;
            forever begin
                @(posedge clk);
                for (int i = L - 1; i > 0; i--) pipe[i] <= pipe[i-1];
                if (ram_en[g] && ram_we[g] == 4'h0) pipe[0] <= mem[ram_addr[g][7:0]];
                else                                pipe[0] <= $urandom();
                if (ram_en[g])
                    for (int b = 0; b < 4; b++)
                        if (ram_we[g][b]) mem[ram_addr[g][7:0]][8*b +: 8] <= ram_wdata[g][8*b +: 8];
            end
        end

        // Model: age counts cycles since an accepted load (-1 when idle).
        initial begin
            for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
            ref_mem[8'h40] = 32'hDEAD_BEEF;
            age       = -1;
            exp_rdata = '0;
            pending   = '0;
            forever begin
                @(negedge clk);
                e_stall = 1'b0; e_en = 1'b0; e_mis = 1'b0; e_we = 4'h0;
                if (rst) begin
                    if (age < 0) begin
                        if ((mem_read || mem_write) && addr[1:0] != 2'b00) e_mis = 1'b1;
                        else if (mem_read) begin e_stall = 1'b1; e_en = 1'b1; end
                        else if (mem_write) begin e_en = 1'b1; e_we = 4'hF; end
                    end else if (age <= L) begin
                        e_stall = 1'b1;
                    end
                end
                check($sformatf("L%0d stall", L),     32'(stall[g]),    32'(e_stall));
                check($sformatf("L%0d ram_en", L),    32'(ram_en[g]),   32'(e_en));
                check($sformatf("L%0d ram_we", L),    32'(ram_we[g]),   32'(e_we));
                check($sformatf("L%0d misalign", L),  32'(misalign[g]), 32'(e_mis));
                check($sformatf("L%0d rdata", L),     rdata[g],         exp_rdata);
                check($sformatf("L%0d ram_addr", L),  32'(ram_addr[g]), 32'(addr[31:2]));
                check($sformatf("L%0d ram_wdata", L), ram_wdata[g],     wdata);

                if (!rst) begin
                    age       = -1;
                    exp_rdata = '0;
                end else if (age < 0) begin
                    if (addr[1:0] == 2'b00) begin
                        if (mem_read) begin
                            pending = ref_mem[addr[9:2]];
                            age     = 1;
                        end else if (mem_write) begin
                            ref_mem[addr[9:2]] = wdata;
                        end
                    end
                end else if (age == L) begin
                    exp_rdata = pending;
                    age       = L + 1;
                end else if (age == L + 1) begin
                    age = -1;
                end else begin
                    age++;
                end
            end
        end
    end

    // Advance to the next cycle, drive its inputs, then wait for mid-cycle sampling.
    task automatic cyc(input logic rs, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        rst = rs; mem_read = r; mem_write = w; addr = a; wdata = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b0; mem_read = 1'b1; mem_write = 1'b0; addr = 32'h100; wdata = '0;

        // Reset held with a pending read request.
        @(negedge clk);
        cyc(1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
        check("reset stall",  32'(stall[0]),  32'h0);
        check("reset ram_en", 32'(ram_en[0]), 32'h0);
        check("reset rdata",  rdata[0],       32'h0);
        idle(2);

        // Load 0x100 with LAT=2, held by the stalled datapath.
        cyc(1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
        check("load c0 ram_en",   32'(ram_en[0]),   32'h1);
        check("load c0 ram_addr", 32'(ram_addr[0]), 32'h40);
        check("load c0 stall",    32'(stall[0]),    32'h1);
        cyc(1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
        check("load c1 stall", 32'(stall[0]), 32'h1);
        cyc(1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
        check("load c2 stall", 32'(stall[0]), 32'h1);
        cyc(1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
        check("load c3 stall", 32'(stall[0]), 32'h0);
        check("load c3 rdata", rdata[0],      32'hDEAD_BEEF);
        idle(4);

        // Store followed immediately by a load of the same word.
        cyc(1'b1, 1'b0, 1'b1, 32'h200, 32'h1234_5678);
        check("store ram_we", 32'(ram_we[0]), 32'hF);
        check("store stall",  32'(stall[0]),  32'h0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
        check("store-load rdata", rdata[0], 32'h1234_5678);
        idle(4);

        // Misaligned load.
        cyc(1'b1, 1'b1, 1'b0, 32'h102, 32'h0);
        check("misalign flag",   32'(misalign[0]), 32'h1);
        check("misalign ram_en", 32'(ram_en[0]),   32'h0);
        check("misalign stall",  32'(stall[0]),    32'h0);
        check("misalign rdata",  rdata[0],         32'h1234_5678);
        idle(4);

        // Read and write together: the read wins.
        cyc(1'b1, 1'b1, 1'b1, 32'h300, 32'hCAFE_F00D);
        check("conflict ram_we", 32'(ram_we[0]), 32'h0);
        check("conflict ram_en", 32'(ram_en[0]), 32'h1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 32'h300, 32'hCAFE_F00D);
        check("conflict rdata", rdata[0], 32'h10C0_00C0);
        idle(4);

        // Reset during the first RD_WAIT cycle aborts the load.
        cyc(1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        check("abort stall", 32'(stall[0]), 32'h0);
        check("abort rdata", rdata[0],      32'h0);
        idle(4);
        check("abort no late capture", rdata[0], 32'h0);

        // LAT=1 instance: stall for two cycles, data valid in cycle 2.
        cyc(1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
        check("lat1 c0 stall", 32'(stall[1]), 32'h1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("lat1 c1 stall", 32'(stall[1]), 32'h1);
        check("lat1 c1 rdata", rdata[1],      32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("lat1 c2 stall", 32'(stall[1]), 32'h0);
        check("lat1 c2 rdata", rdata[1],      32'hDEAD_BEEF);
        idle(3);

        // Random traffic, including misalignment, conflicts and sporadic resets.
        for (int c = 0; c < 3000; c++) begin
            logic [21:0] hi;
            logic [7:0]  word;
            logic [1:0]  lo;
            hi   = ($urandom_range(0, 3) == 0) ? 22'($urandom()) : 22'h0;
            word = 8'($urandom());
            lo   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 2) == 0), {hi, word, lo}, $urandom());
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
